// File: rtl/instruction_sequencer.sv
// Instruction sequencer: fetches 16-bit words from an 8-bit addressed instruction
// memory and issues them to the control unit, with a single-level LOOP and HALT.
module instruction_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  start_pc,
    input  logic        stall,
    output logic [7:0]  imem_addr,
    output logic        imem_rd_en,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instruction,
    output logic [7:0]  pc,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, FETCH, DECODE, ISSUE} state_t;

    typedef enum logic [2:0] {
        OP_NOP, OP_LOAD_ADDR, OP_LOAD_WEIGHT, OP_LOAD_INPUTS,
        OP_VALID, OP_STORE, OP_LOOP, OP_HALT
    } opcode_t;

    state_t      state, state_nxt;
    logic [15:0] ir;
    logic        loop_active;
    logic [4:0]  loop_cnt;
    opcode_t     opcode;
    logic [4:0]  loop_n;
    logic [7:0]  loop_target;

    assign opcode      = opcode_t'(ir[15:13]);
    assign loop_n      = ir[12:8];
    assign loop_target = ir[7:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   state_nxt = DECODE;
            DECODE:  state_nxt = ISSUE;
            ISSUE:   if (!stall) state_nxt = (opcode == OP_HALT) ? IDLE : FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        imem_rd_en = (state == FETCH);
        imem_addr  = pc;
    end

    // instruction and done default to zero so each issue/halt is a single-cycle pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= '0;
            ir          <= '0;
            loop_active <= 1'b0;
            loop_cnt    <= '0;
            instruction <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            instruction <= '0;
            done        <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pc   <= start_pc;
                        busy <= 1'b1;
                    end
                end
                DECODE: ir <= imem_rdata;
                ISSUE: begin
                    if (!stall) begin
                        case (opcode)
                            OP_LOOP: begin
                                if (!loop_active) begin
                                    if (loop_n != 5'd0) begin
                                        loop_active <= 1'b1;
                                        loop_cnt    <= loop_n - 5'd1;
                                        pc          <= loop_target;
                                    end else begin
                                        pc <= pc + 8'd1;
                                    end
                                end else if (loop_cnt != 5'd0) begin
                                    loop_cnt <= loop_cnt - 5'd1;
                                    pc       <= loop_target;
                                end else begin
                                    loop_active <= 1'b0;
                                    pc          <= pc + 8'd1;
                                end
                            end
                            OP_HALT: begin
                                busy        <= 1'b0;
                                done        <= 1'b1;
                                loop_active <= 1'b0;
                            end
                            default: begin
                                instruction <= ir;
                                pc          <= pc + 8'd1;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/instruction_sequencer.md
INSTRUCTION_SEQUENCER -- requirements
Module: instruction_sequencer

Interface
REQ-001 Block SHALL have no parameters; instruction memory address width fixed at 8 bits (256 words).
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  one-cycle pulse; begins program execution at start_pc when idle.
REQ-005 start_pc  in  8  first instruction address, sampled on accepted start.
REQ-006 stall  in  1  downstream busy; holds the pending issue while high.
REQ-007 imem_addr  out  8  instruction memory read address (= pc).
REQ-008 imem_rd_en  out  1  instruction memory read enable; memory returns imem_rdata the following cycle.
REQ-009 imem_rdata  in  16  instruction memory read data.
REQ-010 instruction  out  16  registered instruction bus to the control unit; 16'h0000 (NOP) when not issuing.
REQ-011 pc  out  8  current program counter.
REQ-012 busy  out  1  high from accepted start until HALT or reset.
REQ-013 done  out  1  one-cycle pulse when HALT is executed.

Function
REQ-014 Opcode field instruction[15:13]: 000 NOP, 001 LOAD_ADDR, 010 LOAD_WEIGHT, 011 LOAD_INPUTS, 100 VALID, 101 STORE, 110 LOOP, 111 HALT.
REQ-015 FSM states: IDLE, FETCH, DECODE, ISSUE.
REQ-016 IDLE: start=1 -> pc<=start_pc, busy<=1, go FETCH; start=0 -> stay.
REQ-017 FETCH: imem_rd_en=1, imem_addr=pc; next state DECODE unconditionally.
REQ-018 DECODE: ir<=imem_rdata; next state ISSUE.
REQ-019 ISSUE with stall=1: stay in ISSUE, instruction=16'h0000, pc and loop state unchanged.
REQ-020 ISSUE with stall=0, opcode 000-101: instruction<=ir verbatim for exactly one cycle, pc<=pc+1, go FETCH.
REQ-021 instruction SHALL be 16'h0000 in every cycle other than the single cycle following an ISSUE of opcodes 000-101; the control unit acts on each cycle, so a non-NOP is never presented twice per issue.
REQ-022 LOOP fields: count N = ir[12:8] (5 bits), target T = ir[7:0]; LOOP is never forwarded (instruction stays 0).
REQ-023 LOOP with loop_active=0, N!=0: loop_active<=1, loop_cnt<=N-1, pc<=T.
REQ-024 LOOP with loop_active=1, loop_cnt!=0: loop_cnt<=loop_cnt-1, pc<=T.
REQ-025 LOOP with loop_active=1, loop_cnt=0: loop_active<=0, pc<=pc+1.
REQ-026 LOOP with loop_active=0, N=0: pc<=pc+1 (no jump); body therefore runs N+1 times total; one loop level only, no nesting.
REQ-027 After LOOP (stall=0), next state FETCH.
REQ-028 HALT (stall=0): not forwarded, busy<=0, done<=1 for one cycle, loop_active<=0, go IDLE; pc holds HALT address.
REQ-029 pc+1 SHALL wrap 8'hFF -> 8'h00.
REQ-030 start while busy=1 SHALL be ignored.
REQ-031 Stall is honoured only in ISSUE; stall in FETCH/DECODE has no effect.

Reset
REQ-032 reset=0 SHALL immediately force state=IDLE, pc=0, ir=0, loop_active=0, loop_cnt=0, instruction=16'h0000, imem_rd_en=0, busy=0, done=0.
REQ-033 Reset mid-program SHALL abandon the program with no further issue; a later start runs from start_pc with clean loop state.

Verification
REQ-034 mem[0]=16'h2005, mem[1]=16'h4000, mem[2]=16'hE000, start, start_pc=0 -> instruction 16'h2005 one cycle, 16'h4000 one cycle, zeros elsewhere; single done pulse; busy low afterwards.
REQ-035 mem[0]=16'h8000, mem[1]=16'hC200 (LOOP N=2, T=0), mem[2]=16'hE000 -> 16'h8000 issued exactly 3 times, LOOP never seen on instruction, then done.
REQ-036 stall held 5 cycles while in ISSUE with ir=16'hA000 -> instruction 0 during stall; 16'hA000 issued exactly once after release; pc advances once.
REQ-037 start_pc=8'hFF, mem[FF]=16'h6000, mem[00]=16'hE000 -> 16'h6000 issued, pc wraps to 0, HALT executes, done pulses.
REQ-038 reset asserted mid-loop of REQ-035 program -> all outputs 0 asynchronously; restart -> 16'h8000 again issued exactly 3 times.
REQ-039 start pulsed while busy -> ignored; pc and issue sequence unchanged.
